// File: rtl/minimips_pkg.sv
// Shared MiniMIPS definitions: ALU operation codes and the serial adder FSM encoding.
package minimips_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 2'd3 is never entered; the sequencer treats it as IDLE if it ever shows up.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sadd_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder shared by the bit-serial add/subtract sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_out,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: a single full adder walks the operands LSB first over WIDTH
// cycles. Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
module serial_adder_ctrl
  import minimips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int            CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  sadd_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result_sr;
  logic [WIDTH-1:0] result_next;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_full_adder (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .sum       (fa_sum),
    .carry_out (fa_cout),
    .carry_in  (carry)
  );

  // Result register after this step: shift right and drop the new sum bit into the MSB.
  always_comb begin
    result_next            = result_sr >> 1;
    result_next[WIDTH-1]   = fa_sum;
  end

  // Sequencer FSM with datapath shift registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      result_sr <= '0;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      result_o  <= '0;
      cout_o    <= 1'b0;
      ovf_o     <= 1'b0;
      zero_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_sr      <= a_i;
            b_sr      <= (op_i == OP_SUB) ? ~b_i : b_i;
            carry     <= (op_i == OP_SUB);
            cnt       <= '0;
            result_sr <= '0;
            ready_o   <= 1'b0;
            state     <= S_RUN;
          end else begin
            ready_o <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_RUN: begin
          result_sr <= result_next;
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          carry     <= fa_cout;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            result_o <= result_next;
            cout_o   <= fa_cout;
            ovf_o    <= carry ^ fa_cout;
            zero_o   <= (result_next == '0);
            ready_o  <= 1'b1;
            done_o   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          ready_o <= 1'b1;
          done_o  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance checked every cycle against an
// arithmetic model, plus a 32-bit instance exercised with directed operations.
module tb_serial_adder_ctrl;
  import minimips_pkg::*;

  localparam int W  = 8;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, op;
  logic [W-1:0]  a, b, result;
  logic          ready, done, cout, ovf, zero;
  logic          start_w, op_w;
  logic [WW-1:0] a_w, b_w, result_w;
  logic          ready_w, done_w, cout_w, ovf_w, zero_w;

  int checks     = 0;
  int errors     = 0;
  int dut_dones  = 0;
  int ops_issued = 0;
  logic cmp_on   = 1'b0;

  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .ready_o(ready), .done_o(done), .result_o(result), .cout_o(cout), .ovf_o(ovf), .zero_o(zero)
  );

  serial_adder_ctrl #(.WIDTH(WW)) dut_w (
    .clk(clk), .rst_n(rst_n), .start_i(start_w), .op_i(op_w), .a_i(a_w), .b_i(b_w),
    .ready_o(ready_w), .done_o(done_w), .result_o(result_w), .cout_o(cout_w), .ovf_o(ovf_w),
    .zero_o(zero_w)
  );

  // Reference arithmetic on w-bit unsigned/two's-complement operands.
  function automatic exp_t refCalc(input logic o, input logic [63:0] x_in, input logic [63:0] y_in,
                                   input int w);
    logic [63:0] mask, x, y, s;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    x = x_in & mask;
    y = y_in & mask;
    s = o ? (x - y) : (x + y);
    e.res  = s & mask;
    e.cout = o ? (x >= y) : s[w];
    if (o)
      e.ovf = (x[w-1] != y[w-1]) && (e.res[w-1] != x[w-1]);
    else
      e.ovf = (x[w-1] == y[w-1]) && (e.res[w-1] != x[w-1]);
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: an accepted start produces its result WIDTH edges later.
  logic m_busy      = 1'b0;
  int   m_rem       = 0;
  int   m_completed = 0;
  logic m_done      = 1'b0;
  exp_t m_pend      = '0;
  exp_t m_out       = '0;

  // Behavioural model of the 8-bit instance, advanced on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rem  = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_out  = m_pend;
          m_done = 1'b1;
          m_completed++;
        end
      end else if (start) begin
        m_pend = refCalc(op, 64'(a), 64'(b), W);
        m_busy = 1'b1;
        m_rem  = W;
      end
    end
  end

  // Every-cycle comparison of the 8-bit instance against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      compare("ready", 64'(ready), 64'(!m_busy));
      compare("done", 64'(done), 64'(m_done));
      compare("result", 64'(result), m_out.res);
      compare("cout", 64'(cout), 64'(m_out.cout));
      compare("ovf", 64'(ovf), 64'(m_out.ovf));
      compare("zero", 64'(zero), 64'(m_out.zero));
      if (done === 1'b1) dut_dones++;
    end
  end

  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    ops_issued++;
  endtask

  task automatic waitDone(output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1) begin
        found = 1;
        lat   = k;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done_o, expected one within 40 cycles");
    end
  endtask

  task automatic applyStimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int lat);
    @(negedge clk);
    issue(o, x, y);
    waitDone(lat);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] r, input logic c,
                             input logic o, input logic z);
    compare({name, "_result"}, 64'(result), 64'(r));
    compare({name, "_model_result"}, m_out.res, 64'(r));
    compare({name, "_cout"}, 64'(cout), 64'(c));
    compare({name, "_model_cout"}, 64'(m_out.cout), 64'(c));
    compare({name, "_ovf"}, 64'(ovf), 64'(o));
    compare({name, "_model_ovf"}, 64'(m_out.ovf), 64'(o));
    compare({name, "_zero"}, 64'(zero), 64'(z));
    compare({name, "_model_zero"}, 64'(m_out.zero), 64'(z));
  endtask

  task automatic checkReset(input string name);
    compare({name, "_ready"}, 64'(ready), 64'd1);
    compare({name, "_done"}, 64'(done), 64'd0);
    compare({name, "_result"}, 64'(result), 64'd0);
    compare({name, "_flags"}, 64'({cout, ovf, zero}), 64'd0);
    compare({name, "_ready_w"}, 64'(ready_w), 64'd1);
    compare({name, "_result_w"}, 64'(result_w), 64'd0);
  endtask

  task automatic wideOp(input string name, input logic o, input logic [WW-1:0] x,
                        input logic [WW-1:0] y, input logic [WW-1:0] r, input logic c,
                        input logic ov, input logic z);
    bit   found = 0;
    int   lat   = -1;
    exp_t e;
    @(negedge clk);
    start_w = 1'b1;
    op_w    = o;
    a_w     = x;
    b_w     = y;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(negedge clk);
      if (k == 1) start_w = 1'b0;
      if (done_w === 1'b1) begin
        found = 1;
        lat   = k;
      end
    end
    e = refCalc(o, 64'(x), 64'(y), WW);
    compare({name, "_latency"}, 64'(lat), 64'(WW + 1));
    compare({name, "_result"}, 64'(result_w), 64'(r));
    compare({name, "_model_result"}, e.res, 64'(r));
    compare({name, "_flags"}, 64'({cout_w, ovf_w, zero_w}), 64'({c, ov, z}));
    compare({name, "_model_flags"}, 64'({e.cout, e.ovf, e.zero}), 64'({c, ov, z}));
  endtask

  // Bound on total run time in case the design stalls in a way the per-op bounds miss.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed vectors, back-to-back and abort scenarios, then randomised operations.
  initial begin
    int lat;
    start = 1'b0; op = 1'b0; a = '0; b = '0;
    start_w = 1'b0; op_w = 1'b0; a_w = '0; b_w = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    #2 checkReset("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(OP_ADD, 8'h3C, 8'h05, lat);
    compare("add_latency", 64'(lat), 64'(W + 1));
    checkOutput("add_3c_05", 8'h41, 1'b0, 1'b0, 1'b0);

    applyStimulus(OP_ADD, 8'h7F, 8'h01, lat);
    checkOutput("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 8'hFF, 8'h01, lat);
    checkOutput("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(OP_SUB, 8'h05, 8'h07, lat);
    checkOutput("sub_05_07", 8'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_SUB, 8'h80, 8'h01, lat);
    checkOutput("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0);

    applyStimulus(OP_ADD, 8'h10, 8'h20, lat);
    checkOutput("b2b_first", 8'h30, 1'b0, 1'b0, 1'b0);
    issue(OP_SUB, 8'h30, 8'h11);
    @(negedge clk);
    start = 1'b0;
    compare("b2b_no_idle_ready", 64'(ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1; op = OP_ADD; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
    end
    waitDone(lat);
    checkOutput("b2b_second", 8'h1F, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    issue(OP_ADD, 8'h55, 8'h22);
    repeat (4) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    ops_issued--;
    #1 checkReset("abort");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(OP_ADD, 8'h01, 8'h01, lat);
    checkOutput("after_abort", 8'h02, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      waitDone(lat);
      compare("rand_latency", 64'(lat), 64'(W + 1));
    end

    wideOp("w_add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    wideOp("w_sub_borrow", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    wideOp("w_add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    wideOp("w_sub_equal", OP_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    compare("done_count", 64'(dut_dones), 64'(ops_issued));
    compare("model_count", 64'(m_completed), 64'(ops_issued));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
